issue_exe_pipe: RTL and testbench

- Parametrised pipeline register between the issue stage and the EXE stage.
- Carries up to LANES instruction slots per cycle, each with a decoded control payload and SRC_PER_LANE captured register operands.
- Uses a ready/valid bundle handshake with EXE in place of a bare stall input.
- Keeps held operands current by snooping writeback ports while an instruction waits in the stage, so stalled instructions never execute on stale register values.

---
 rtl/issue_exe_pipe.sv | 199 +++++++++++++++++++
 tb/tb_issue_exe_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_exe_pipe.sv
// Issue->EXE pipeline register with ready/valid handshake and writeback snooping of held operands.
// Define ISSUE_EXE_SKID_EN to add a skid entry and make in_ready a register output.
module issue_exe_pipe #(
  parameter int unsigned LANES        = 2,
  parameter int unsigned PAYLOAD_W    = 96,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SRC_PER_LANE = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [LANES-1:0]                     in_valid,
  input  logic [LANES*PAYLOAD_W-1:0]           in_payload,
  input  logic [LANES*SRC_PER_LANE*5-1:0]      in_raddr,
  input  logic [LANES*SRC_PER_LANE*DATA_W-1:0] in_rdata,
  output logic                                 in_ready,
  input  logic                                 flush,
  input  logic [LANES-1:0]                     wb_we,
  input  logic [LANES*5-1:0]                   wb_addr,
  input  logic [LANES*DATA_W-1:0]              wb_data,
  output logic [LANES-1:0]                     out_valid,
  output logic [LANES*PAYLOAD_W-1:0]           out_payload,
  output logic [LANES*SRC_PER_LANE*5-1:0]      out_raddr,
  output logic [LANES*SRC_PER_LANE*DATA_W-1:0] out_rdata,
  input  logic                                 out_ready
);

  localparam int unsigned NumSrc = LANES * SRC_PER_LANE;

  // Highest matching writeback port wins; r0 is never forwarded.
  function automatic logic [DATA_W-1:0] snoop(input logic [4:0]              addr,
                                              input logic [DATA_W-1:0]       data,
                                              input logic [LANES-1:0]        we,
                                              input logic [LANES*5-1:0]      waddr,
                                              input logic [LANES*DATA_W-1:0] wdata);
    logic [DATA_W-1:0] res;
    res = data;
    if (addr != 5'd0) begin
      for (int k = 0; k < LANES; k++) begin
        if (we[k] && (waddr[k*5 +: 5] == addr)) res = wdata[k*DATA_W +: DATA_W];
      end
    end
    return res;
  endfunction

  logic [LANES-1:0]           m_valid_q, m_valid_d;
  logic [LANES*PAYLOAD_W-1:0] m_payload_q, m_payload_d;
  logic [NumSrc*5-1:0]        m_raddr_q, m_raddr_d;
  logic [NumSrc*DATA_W-1:0]   m_rdata_q, m_rdata_d;
  logic [NumSrc*DATA_W-1:0]   m_rdata_fwd, in_rdata_fwd;

  logic in_xfer;
  assign in_xfer = in_ready & (|in_valid);

`ifdef ISSUE_EXE_SKID_EN
  logic [LANES-1:0]           s_valid_q, s_valid_d;
  logic [LANES*PAYLOAD_W-1:0] s_payload_q, s_payload_d;
  logic [NumSrc*5-1:0]        s_raddr_q, s_raddr_d;
  logic [NumSrc*DATA_W-1:0]   s_rdata_q, s_rdata_d;
  logic [NumSrc*DATA_W-1:0]   s_rdata_fwd;
  logic                       in_ready_q, in_ready_d;
`endif

  always_comb begin
    m_rdata_fwd  = m_rdata_q;
    in_rdata_fwd = in_rdata;
`ifdef ISSUE_EXE_SKID_EN
    s_rdata_fwd  = s_rdata_q;
`endif
    for (int i = 0; i < LANES; i++) begin
      for (int s = 0; s < SRC_PER_LANE; s++) begin
        if (m_valid_q[i]) begin
          m_rdata_fwd[(i*SRC_PER_LANE+s)*DATA_W +: DATA_W] =
            snoop(m_raddr_q[(i*SRC_PER_LANE+s)*5 +: 5],
                  m_rdata_q[(i*SRC_PER_LANE+s)*DATA_W +: DATA_W], wb_we, wb_addr, wb_data);
        end
`ifdef ISSUE_EXE_SKID_EN
        if (s_valid_q[i]) begin
          s_rdata_fwd[(i*SRC_PER_LANE+s)*DATA_W +: DATA_W] =
            snoop(s_raddr_q[(i*SRC_PER_LANE+s)*5 +: 5],
                  s_rdata_q[(i*SRC_PER_LANE+s)*DATA_W +: DATA_W], wb_we, wb_addr, wb_data);
        end
`endif
        // Bypass on capture: same-cycle writeback beats the stale register file read.
        in_rdata_fwd[(i*SRC_PER_LANE+s)*DATA_W +: DATA_W] =
          snoop(in_raddr[(i*SRC_PER_LANE+s)*5 +: 5],
                in_rdata[(i*SRC_PER_LANE+s)*DATA_W +: DATA_W], wb_we, wb_addr, wb_data);
      end
    end
  end

`ifdef ISSUE_EXE_SKID_EN
  assign in_ready = in_ready_q;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_payload_d = m_payload_q;
    m_raddr_d   = m_raddr_q;
    m_rdata_d   = m_rdata_fwd;
    s_valid_d   = s_valid_q;
    s_payload_d = s_payload_q;
    s_raddr_d   = s_raddr_q;
    s_rdata_d   = s_rdata_fwd;
    if (flush) begin
      m_valid_d = '0;
      s_valid_d = '0;
    end else if (out_ready) begin
      if (|s_valid_q) begin
        m_valid_d   = s_valid_q;
        m_payload_d = s_payload_q;
        m_raddr_d   = s_raddr_q;
        m_rdata_d   = s_rdata_fwd;
      end else if (in_xfer) begin
        m_valid_d   = in_valid;
        m_payload_d = in_payload;
        m_raddr_d   = in_raddr;
        m_rdata_d   = in_rdata_fwd;
      end else begin
        m_valid_d = '0;
      end
      s_valid_d = '0;
    end else if (in_xfer) begin
      if (|m_valid_q) begin
        s_valid_d   = in_valid;
        s_payload_d = in_payload;
        s_raddr_d   = in_raddr;
        s_rdata_d   = in_rdata_fwd;
      end else begin
        m_valid_d   = in_valid;
        m_payload_d = in_payload;
        m_raddr_d   = in_raddr;
        m_rdata_d   = in_rdata_fwd;
      end
    end
    in_ready_d = ~(|s_valid_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_valid_q   <= '0;
      s_payload_q <= '0;
      s_raddr_q   <= '0;
      s_rdata_q   <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      s_valid_q   <= s_valid_d;
      s_payload_q <= s_payload_d;
      s_raddr_q   <= s_raddr_d;
      s_rdata_q   <= s_rdata_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  assign in_ready = ~(|m_valid_q) | out_ready;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_payload_d = m_payload_q;
    m_raddr_d   = m_raddr_q;
    m_rdata_d   = m_rdata_fwd;
    if (flush) begin
      m_valid_d = '0;
    end else if (in_xfer) begin
      m_valid_d   = in_valid;
      m_payload_d = in_payload;
      m_raddr_d   = in_raddr;
      m_rdata_d   = in_rdata_fwd;
    end else if (out_ready) begin
      m_valid_d = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q   <= '0;
      m_payload_q <= '0;
      m_raddr_q   <= '0;
      m_rdata_q   <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_payload_q <= m_payload_d;
      m_raddr_q   <= m_raddr_d;
      m_rdata_q   <= m_rdata_d;
    end
  end

  always_comb begin
    out_payload = '0;
    for (int i = 0; i < LANES; i++) begin
      out_payload[i*PAYLOAD_W +: PAYLOAD_W] =
        m_payload_q[i*PAYLOAD_W +: PAYLOAD_W] & {PAYLOAD_W{m_valid_q[i]}};
    end
  end

  assign out_valid = m_valid_q;
  assign out_raddr = m_raddr_q;
  assign out_rdata = m_rdata_q;

endmodule

// File: tb/tb_issue_exe_pipe.sv
// Directed self-checking bench for issue_exe_pipe (LANES=2); follows ISSUE_EXE_SKID_EN if defined.
module tb_issue_exe_pipe;

  localparam int unsigned LANES = 2;
  localparam int unsigned PW    = 96;
  localparam int unsigned DW    = 32;
  localparam int unsigned SRC   = 2;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [LANES-1:0]        in_valid;
  logic [LANES*PW-1:0]     in_payload;
  logic [LANES*SRC*5-1:0]  in_raddr;
  logic [LANES*SRC*DW-1:0] in_rdata;
  logic                    in_ready;
  logic                    flush;
  logic [LANES-1:0]        wb_we;
  logic [LANES*5-1:0]      wb_addr;
  logic [LANES*DW-1:0]     wb_data;
  logic [LANES-1:0]        out_valid;
  logic [LANES*PW-1:0]     out_payload;
  logic [LANES*SRC*5-1:0]  out_raddr;
  logic [LANES*SRC*DW-1:0] out_rdata;
  logic                    out_ready;

  int n_checks = 0;
  int n_errs   = 0;

  issue_exe_pipe #(
    .LANES(LANES), .PAYLOAD_W(PW), .DATA_W(DW), .SRC_PER_LANE(SRC)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_payload(in_payload),
    .in_raddr(in_raddr), .in_rdata(in_rdata), .in_ready(in_ready), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_payload(out_payload), .out_raddr(out_raddr), .out_rdata(out_rdata),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mk_pay(input logic [31:0] pc);
    return {32'h0000_00a5, 32'h0, pc};
  endfunction

  function automatic logic [2*PW-1:0] mk_bundle(input logic [31:0] pc0);
    return {mk_pay(pc0 + 32'd4), mk_pay(pc0)};
  endfunction

  logic [2*PW-1:0] b_last;
  logic [2*PW-1:0] b_new;
  int              accepts;
  logic            acc;
  logic            exp_rdy;

  initial begin
    rstn = 1'b0; in_valid = '0; in_payload = '0; in_raddr = '0; in_rdata = '0;
    flush = 1'b0; wb_we = '0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", out_valid, 2'b00);
    check("rst_out_payload", out_payload, '0);
    check("rst_in_ready", in_ready, 1'b1);
    tick();
    rstn = 1'b1;
    tick();

    // Streaming: each bundle appears one cycle after acceptance, back to back.
    for (int n = 0; n < 4; n++) begin
      b_last = mk_bundle(32'h1c00_0000 + 32'(8 * n));
      in_valid = 2'b11;
      in_payload = b_last;
      tick();
      check("stream_valid", out_valid, 2'b11);
      check("stream_payload", out_payload, b_last);
    end

    // Stall for 5 cycles while a new bundle is offered.
    b_new = mk_bundle(32'h1c00_0100);
    out_ready = 1'b0;
    in_payload = b_new;
    accepts = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
`ifdef ISSUE_EXE_SKID_EN
      exp_rdy = (c == 0);
`else
      exp_rdy = 1'b0;
`endif
      check("stall_in_ready", in_ready, exp_rdy);
      acc = in_ready & (|in_valid);
      tick();
      if (acc) begin
        accepts++;
        in_valid = '0;
      end
      check("stall_payload_hold", out_payload, b_last);
    end
    out_ready = 1'b1;
    #1;
    acc = in_ready & (|in_valid);
    tick();
    if (acc) accepts++;
    in_valid = '0;
    check("release_payload", out_payload, b_new);
    check("release_accepts", 32'(accepts), 32'd1);
    tick();
    check("release_drain", out_valid, 2'b00);

    // Refresh during stall; r0 source must keep its captured value.
    in_valid = 2'b01;
    in_payload = mk_bundle(32'h1c00_0200);
    in_raddr = '0;
    in_raddr[9:5] = 5'd5;
    in_rdata = '0;
    in_rdata[31:0] = 32'h11;
    in_rdata[63:32] = 32'h11;
    tick();
    in_valid = '0;
    out_ready = 1'b0;
    check("refresh_capture", out_rdata[63:32], 32'h11);
    wb_we = 2'b11;
    wb_addr = {5'd0, 5'd5};
    wb_data = {32'hcd, 32'hab};
    tick();
    check("refresh_src1", out_rdata[63:32], 32'hab);
    check("refresh_r0_src0", out_rdata[31:0], 32'h11);
    wb_addr = {5'd5, 5'd5};
    wb_data = {32'hcd, 32'hee};
    tick();
    check("refresh_priority", out_rdata[63:32], 32'hcd);
    wb_we = '0;
    tick();
    check("refresh_hold", out_rdata[63:32], 32'hcd);
    check("refresh_valid_hold", out_valid, 2'b01);
    out_ready = 1'b1;
    tick();
    check("refresh_drain", out_valid, 2'b00);

    // Bypass on capture: both ports write r7, port 1 wins.
    in_valid = 2'b01;
    in_raddr = '0;
    in_raddr[4:0] = 5'd7;
    in_rdata = '0;
    in_rdata[31:0] = 32'h99;
    wb_we = 2'b11;
    wb_addr = {5'd7, 5'd7};
    wb_data = {32'h2, 32'h1};
    tick();
    wb_we = '0;
    check("bypass_capture", out_rdata[31:0], 32'h2);

    // Lane masking: invalid lane 0 payload reads as zero.
    b_new = mk_bundle(32'h1c00_0300);
    in_valid = 2'b10;
    in_payload = b_new;
    tick();
    check("mask_valid", out_valid, 2'b10);
    check("mask_lane0", out_payload[PW-1:0], '0);
    check("mask_lane1", out_payload[2*PW-1:PW], b_new[2*PW-1:PW]);

    // Flush with the stage full and a new input offered.
    out_ready = 1'b0;
`ifdef ISSUE_EXE_SKID_EN
    in_valid = 2'b11;
    in_payload = mk_bundle(32'h1c00_0400);
    tick();
    check("skid_full_in_ready", in_ready, 1'b0);
`endif
    flush = 1'b1;
    in_valid = 2'b11;
    in_payload = mk_bundle(32'h1c00_0500);
    tick();
    flush = 1'b0;
    in_valid = '0;
    check("flush_valid", out_valid, 2'b00);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    tick();
    check("flush_dropped", out_valid, 2'b00);

    // Flush while in_ready is high: the offered bundle is still discarded.
    flush = 1'b1;
    in_valid = 2'b11;
    #1;
    check("flush2_in_ready", in_ready, 1'b1);
    tick();
    flush = 1'b0;
    in_valid = '0;
    check("flush2_valid", out_valid, 2'b00);

    // Asynchronous reset mid-stall.
    in_valid = 2'b11;
    in_payload = mk_bundle(32'h1c00_0600);
    tick();
    in_valid = '0;
    out_ready = 1'b0;
    tick();
    check("pre_areset_valid", out_valid, 2'b11);
    #2;
    rstn = 1'b0;
    #1;
    check("areset_valid", out_valid, 2'b00);
    check("areset_payload", out_payload, '0);
    check("areset_in_ready", in_ready, 1'b1);
    tick();
    rstn = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_areset_valid", out_valid, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
